// File: rtl/fixed_pkg.sv
// Fixed-point types, RSI FSM state encoding and Q-format constant helper for the RSI path.
package fixed_pkg;

  typedef logic [15:0] uq8_8_t;

  typedef enum logic [1:0] {IDLE, DIV, DONE} rsi_state_t;

  function automatic logic [63:0] hundred_q(input int unsigned fw);
    return 64'd100 << fw;
  endfunction

endpackage

// File: rtl/rsi_div_seq_if.sv
// RS-in / RSI-out valid/ready bus; flags exist only when RSI_THRESH_EN is defined.
interface rsi_div_seq_if #(
  parameter int W    = 16,
  parameter int TAGW = 4
);
  logic            i_rs_valid;
  logic            o_rs_ready;
  logic [W-1:0]    i_rs_scaled;
  logic [TAGW-1:0] i_tag;
  logic            o_rsi_valid;
  logic            i_rsi_ready;
  logic [W-1:0]    o_rsi_scaled;
  logic [TAGW-1:0] o_tag;
`ifdef RSI_THRESH_EN
  logic            o_overbought;
  logic            o_oversold;

  modport slave (
    input  i_rs_valid, i_rs_scaled, i_tag, i_rsi_ready,
    output o_rs_ready, o_rsi_valid, o_rsi_scaled, o_tag, o_overbought, o_oversold
  );
  modport master (
    output i_rs_valid, i_rs_scaled, i_tag, i_rsi_ready,
    input  o_rs_ready, o_rsi_valid, o_rsi_scaled, o_tag, o_overbought, o_oversold
  );
`else
  modport slave (
    input  i_rs_valid, i_rs_scaled, i_tag, i_rsi_ready,
    output o_rs_ready, o_rsi_valid, o_rsi_scaled, o_tag
  );
  modport master (
    output i_rs_valid, i_rs_scaled, i_tag, i_rsi_ready,
    input  o_rs_ready, o_rsi_valid, o_rsi_scaled, o_tag
  );
`endif
endinterface

// File: rtl/udiv_restoring.sv
// Unsigned restoring divider, one quotient bit per cycle for QW cycles after start.
// done is high in the final iteration cycle; quo is the complete quotient while done is high.
module udiv_restoring #(
  parameter int NW = 23,
  parameter int DW = 17,
  parameter int QW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          done,
  output logic [QW-1:0] quo
);
  localparam int CW = (QW > 1) ? $clog2(QW) : 1;

  logic          busy;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dvs;
  logic [DW-1:0] rem;
  logic [DW-1:0] rem_nxt;
  logic [QW-1:0] num_lo;
  logic [QW-1:0] q;
  logic [DW:0]   trial;
  logic          ge;

  // Upper dividend bits start as the remainder; caller guarantees they are below the divisor.
  always_comb begin
    trial   = {rem, num_lo[QW-1]};
    ge      = (trial >= {1'b0, dvs});
    rem_nxt = ge ? DW'(trial - {1'b0, dvs}) : trial[DW-1:0];
  end

  assign quo  = {q[QW-2:0], ge};
  assign done = busy && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      dvs    <= '0;
      rem    <= '0;
      num_lo <= '0;
      q      <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= CW'(QW - 1);
      dvs    <= divisor;
      rem    <= DW'(dividend[NW-1:QW]);
      num_lo <= dividend[QW-1:0];
      q      <= '0;
    end else if (busy) begin
      rem    <= rem_nxt;
      num_lo <= {num_lo[QW-2:0], 1'b0};
      q      <= quo;
      cnt    <= cnt - CW'(1);
      if (cnt == '0) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/rsi_div_seq.sv
// RSI = 100 - 100/(1+RS) via sequential divide; result valid W+1 cycles after accept, held until taken.
// Input ready only in IDLE; optional registered overbought/oversold flags under RSI_THRESH_EN.
module rsi_div_seq
  import fixed_pkg::*;
#(
  parameter int G_IW   = 8,
  parameter int G_FW   = 8,
  parameter int G_TAGW = 4
`ifdef RSI_THRESH_EN
  ,
  parameter int G_OB   = 70,
  parameter int G_OS   = 30
`endif
) (
  input  logic           i_clk,
  input  logic           i_rst,
  rsi_div_seq_if.slave   bus
);
  localparam int W  = G_IW + G_FW;
  localparam int DW = W + 1;
  localparam int NW = 7 + 2 * G_FW;
  localparam logic [W-1:0]  HUNDRED = W'(hundred_q(G_FW));
  localparam logic [NW-1:0] NUM0    = NW'(hundred_q(2 * G_FW));

  rsi_state_t        state;
  rsi_state_t        state_nxt;
  logic              accept;
  logic              start;
  logic              div_done;
  logic              commit;
  logic [W-1:0]      quo;
  logic [W-1:0]      rsi_nxt;
  logic [DW-1:0]     denom;
  logic [W-1:0]      rsi_q;
  logic [G_TAGW-1:0] tag_q;

  assign bus.o_rs_ready  = (state == IDLE) && !i_rst;
  assign accept          = bus.i_rs_valid && bus.o_rs_ready;
  assign denom           = (DW'(1) << G_FW) + DW'(bus.i_rs_scaled);
  assign commit          = (state == DIV) && div_done;
  assign rsi_nxt         = HUNDRED - quo;

  assign bus.o_rsi_valid  = (state == DONE);
  assign bus.o_rsi_scaled = rsi_q;
  assign bus.o_tag        = tag_q;

  udiv_restoring #(
    .NW (NW),
    .DW (DW),
    .QW (W)
  ) u_div (
    .clk      (i_clk),
    .rst      (i_rst),
    .start    (start),
    .dividend (NUM0),
    .divisor  (denom),
    .done     (div_done),
    .quo      (quo)
  );

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: if (accept) begin
        state_nxt = DIV;
        start     = 1'b1;
      end
      DIV:  if (div_done) state_nxt = DONE;
      DONE: if (bus.i_rsi_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      rsi_q <= '0;
      tag_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) tag_q <= bus.i_tag;
      if (commit) rsi_q <= rsi_nxt;
    end
  end

`ifdef RSI_THRESH_EN
  localparam logic [W-1:0] OB_Q = W'(G_OB) << G_FW;
  localparam logic [W-1:0] OS_Q = W'(G_OS) << G_FW;

  logic ob_q;
  logic os_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ob_q <= 1'b0;
      os_q <= 1'b0;
    end else if (commit) begin
      ob_q <= (rsi_nxt >= OB_Q);
      os_q <= (rsi_nxt <= OS_Q);
    end
  end

  assign bus.o_overbought = ob_q;
  assign bus.o_oversold   = os_q;
`endif

endmodule

// File: tb/tb_rsi_div_seq.sv
// Randomized and directed check of rsi_div_seq against an arithmetic RSI model.
module tb_rsi_div_seq;
  localparam int IW   = 8;
  localparam int FW   = 8;
  localparam int W    = IW + FW;
  localparam int TAGW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  rsi_div_seq_if #(.W(W), .TAGW(TAGW)) bus ();

  rsi_div_seq #(.G_IW(IW), .G_FW(FW), .G_TAGW(TAGW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // RSI = 100 - 100/(1+RS) in Q(IW.FW), with the quotient truncated.
  function automatic logic [W-1:0] ref_rsi(input logic [W-1:0] rs);
    longint num;
    longint den;
    num = 100 * (longint'(1) << (2 * FW));
    den = (longint'(1) << FW) + longint'(rs);
    return W'((longint'(100) << FW) - num / den);
  endfunction

  task automatic send(input logic [W-1:0] rs, input logic [TAGW-1:0] tg, output int acc);
    bit ok;
    ok  = 1'b0;
    acc = -1;
    bus.i_rs_valid  = 1'b1;
    bus.i_rs_scaled = rs;
    bus.i_tag       = tg;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (bus.o_rs_ready) begin
        acc = cyc;
        ok  = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.i_rs_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_valid(output int vc);
    bit ok;
    ok = 1'b0;
    vc = -1;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (bus.o_rsi_valid) begin
        vc = cyc;
        ok = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!ok) chk("valid_timeout", 0, 1);
  endtask

  task automatic check_result(input string name, input logic [W-1:0] rs,
                              input logic [TAGW-1:0] tg, input int acc, input int vc);
    logic [W-1:0] exp;
    exp = ref_rsi(rs);
    chk({name, "_rsi"}, bus.o_rsi_scaled, exp);
    chk({name, "_tag"}, bus.o_tag, tg);
    chk({name, "_lat"}, vc - acc, W + 1);
`ifdef RSI_THRESH_EN
    chk({name, "_ob"}, bus.o_overbought, exp >= (W'(70) << FW));
    chk({name, "_os"}, bus.o_oversold,   exp <= (W'(30) << FW));
`endif
  endtask

  task automatic release_result();
    bus.i_rsi_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_rsi_ready = 1'b0;
    chk("release_valid", bus.o_rsi_valid, 0);
    chk("release_ready", bus.o_rs_ready, 1);
  endtask

  logic [W-1:0]    dir_rs  [4] = '{16'h0000, 16'h0100, 16'h0300, 16'hFFFF};
  logic [W-1:0]    dir_exp [4] = '{16'h0000, 16'h3200, 16'h4B00, 16'h639D};
  logic [TAGW-1:0] dir_tag [4] = '{4'h1, 4'h2, 4'hA, 4'hF};

  initial begin
    int a, a2, v, hold;
    logic [W-1:0]    rs, snap_rsi;
    logic [TAGW-1:0] tg, snap_tag;
    bit seen;

    bus.i_rs_valid  = 1'b0;
    bus.i_rs_scaled = '0;
    bus.i_tag       = '0;
    bus.i_rsi_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.o_rs_ready, 0);
    chk("rst_valid", bus.o_rsi_valid, 0);
    chk("rst_rsi",   bus.o_rsi_scaled, 0);
    chk("rst_tag",   bus.o_tag, 0);
`ifdef RSI_THRESH_EN
    chk("rst_ob", bus.o_overbought, 0);
    chk("rst_os", bus.o_oversold, 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", bus.o_rs_ready, 1);

    // Directed corner values, including the widest denominator.
    for (int i = 0; i < 4; i++) begin
      send(dir_rs[i], dir_tag[i], a);
      wait_valid(v);
      chk("dir_const", bus.o_rsi_scaled, dir_exp[i]);
      check_result("dir", dir_rs[i], dir_tag[i], a, v);
      release_result();
    end

    // Result held in DONE while a new input waits upstream.
    send(16'h0200, 4'h5, a);
    wait_valid(v);
    check_result("hold", 16'h0200, 4'h5, a, v);
    snap_rsi = bus.o_rsi_scaled;
    snap_tag = bus.o_tag;
    bus.i_rs_valid  = 1'b1;
    bus.i_rs_scaled = 16'h0080;
    bus.i_tag       = 4'h3;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", bus.o_rsi_valid, 1);
      chk("hold_rsi",   bus.o_rsi_scaled, snap_rsi);
      chk("hold_tag",   bus.o_tag, snap_tag);
      chk("hold_rdy",   bus.o_rs_ready, 0);
    end
    release_result();
    a = cyc;
    @(posedge clk); #1;
    bus.i_rs_valid = 1'b0;
    chk("next_accepted", bus.o_rs_ready, 0);
    wait_valid(v);
    check_result("next", 16'h0080, 4'h3, a, v);
    release_result();

    // Downstream ready held high: ignored while busy, one result per W+2 cycles.
    bus.i_rsi_ready = 1'b1;
    send(16'h0100, 4'h6, a);
    wait_valid(v);
    check_result("tp1", 16'h0100, 4'h6, a, v);
    send(16'h0300, 4'h7, a2);
    chk("tp_period", a2 - a, W + 2);
    wait_valid(v);
    check_result("tp2", 16'h0300, 4'h7, a2, v);
    @(posedge clk); #1;
    bus.i_rsi_ready = 1'b0;
    chk("tp_idle", bus.o_rs_ready, 1);

    // Reset during the divide aborts it without presenting a result.
    send(16'h0500, 4'h9, a);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.o_rsi_valid, 0);
    chk("mid_rst_ready", bus.o_rs_ready, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.o_rsi_valid) seen = 1'b1;
    end
    chk("mid_rst_no_result", seen, 0);
    chk("mid_rst_idle", bus.o_rs_ready, 1);
    send(16'h0100, 4'h4, a);
    wait_valid(v);
    chk("post_rst_const", bus.o_rsi_scaled, 16'h3200);
    check_result("post_rst", 16'h0100, 4'h4, a, v);
    release_result();

    // Random RS, tags and downstream stalls.
    for (int n = 0; n < 24; n++) begin
      rs   = W'($urandom_range(0, 65535));
      tg   = TAGW'($urandom_range(0, 15));
      hold = $urandom_range(0, 3);
      send(rs, tg, a);
      wait_valid(v);
      check_result("rnd", rs, tg, a, v);
      repeat (hold) begin
        @(posedge clk); #1;
      end
      chk("rnd_stable", bus.o_rsi_scaled, ref_rsi(rs));
      release_result();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
